layer_priority_mux: RTL and testbench

LAYER_PRIORITY_MUX -- requirements
Module: layer_priority_mux

---
 rtl/layer_priority_mux.sv | 114 +++++++++++
 tb/tb_layer_priority_mux.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/layer_priority_mux.sv
// Layer priority multiplexer with per-layer blink control.
// The lowest-index layer that is drawing, is not transparent and is not
// hidden by its blink FSM wins the pixel. The result is registered, so
// there is one clock of latency. Each layer has its own blink FSM that
// advances on startOfFrame. The layer is hidden on odd phases of the blink.
module layer_priority_mux #(
    parameter int                NUM_LAYERS   = 8,
    parameter int                RGB_W        = 8,
    parameter logic [RGB_W-1:0]  TRANSPARENT  = 8'hFF,
    parameter int                BLINK_FRAMES = 16
) (
    input  logic                          clk,
    input  logic                          resetN,
    input  logic                          startOfFrame,
    input  logic [NUM_LAYERS-1:0]         layer_DR,
    input  logic [NUM_LAYERS*RGB_W-1:0]   layer_RGB,
    input  logic [NUM_LAYERS-1:0]         blink_req,
    input  logic [RGB_W-1:0]              background_RGB,
    output logic [RGB_W-1:0]              RGBOut,
    output logic                          any_DR,
    output logic [$clog2(NUM_LAYERS)-1:0] winner_idx,
    output logic [NUM_LAYERS-1:0]         blinking
);

    localparam int         IDX_W     = $clog2(NUM_LAYERS);
    localparam logic [7:0] LP_FRAMES = 8'(BLINK_FRAMES);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BLINK = 1'b1
    } blink_state_t;

    blink_state_t r_state [NUM_LAYERS];
    logic [7:0]   r_cnt   [NUM_LAYERS];
    logic         r_phase [NUM_LAYERS];

    logic [NUM_LAYERS-1:0] w_hidden;
    logic [NUM_LAYERS-1:0] w_eligible;
    logic                  w_found;
    logic [IDX_W-1:0]      w_idx;
    logic [RGB_W-1:0]      w_rgb;

    // Blink FSMs. A request always reloads, even if it coincides with a
    // frame start. Otherwise each frame start toggles the phase and counts down.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                r_state[i] <= ST_IDLE;
                r_cnt[i]   <= 8'd0;
                r_phase[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                if (blink_req[i]) begin
                    r_state[i] <= ST_BLINK;
                    r_cnt[i]   <= LP_FRAMES;
                    r_phase[i] <= 1'b0;
                end else if (r_state[i] == ST_BLINK && startOfFrame) begin
                    if (r_cnt[i] == 8'd1) begin
                        r_state[i] <= ST_IDLE;
                        r_cnt[i]   <= 8'd0;
                        r_phase[i] <= 1'b0;
                    end else begin
                        r_cnt[i]   <= r_cnt[i] - 8'd1;
                        r_phase[i] <= ~r_phase[i];
                    end
                end
            end
        end
    end

    // Hide and eligibility decode, using only registered blink state.
    always_comb begin
        w_hidden   = '0;
        w_eligible = '0;
        blinking   = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            blinking[i]   = (r_state[i] == ST_BLINK);
            w_hidden[i]   = (r_state[i] == ST_BLINK) && r_phase[i];
            w_eligible[i] = layer_DR[i]
                          && (layer_RGB[i*RGB_W +: RGB_W] != TRANSPARENT)
                          && !w_hidden[i];
        end
    end

    // Fixed priority select. The loop scans downward, so the lowest
    // eligible index is assigned last and wins.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_rgb   = background_RGB;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_found = 1'b1;
                w_idx   = i[IDX_W-1:0];
                w_rgb   = layer_RGB[i*RGB_W +: RGB_W];
            end
        end
    end

    // Output register, which gives one clock of latency.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            RGBOut     <= '0;
            any_DR     <= 1'b0;
            winner_idx <= '0;
        end else begin
            RGBOut     <= w_rgb;
            any_DR     <= w_found;
            winner_idx <= w_idx;
        end
    end

endmodule

// File: tb/tb_layer_priority_mux.sv
// Testbench for layer_priority_mux. It drives directed vectors. An abstract
// frame-count model is checked every cycle, and hand-computed literals are
// checked at the key points.
module tb_layer_priority_mux;

    localparam int NL = 8;
    localparam int W  = 8;
    localparam int BF = 16;

    logic          clk;
    logic          resetN;
    logic          startOfFrame;
    logic [NL-1:0] layer_DR;
    logic [NL*W-1:0] layer_RGB;
    logic [NL-1:0] blink_req;
    logic [W-1:0]  background_RGB;
    logic [W-1:0]  RGBOut;
    logic          any_DR;
    logic [2:0]    winner_idx;
    logic [NL-1:0] blinking;

    int checks = 0;
    int errors = 0;

    layer_priority_mux #(
        .NUM_LAYERS(NL), .RGB_W(W), .TRANSPARENT(8'hFF), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .layer_DR(layer_DR), .layer_RGB(layer_RGB), .blink_req(blink_req),
        .background_RGB(background_RGB), .RGBOut(RGBOut), .any_DR(any_DR),
        .winner_idx(winner_idx), .blinking(blinking)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model. fs[i] is the number of frame starts since the blink began,
    // or -1 when the layer is not blinking. The layer is hidden on odd counts.
    int            fs [NL];
    logic [W-1:0]  exp_rgb;
    logic          exp_any;
    logic [2:0]    exp_idx;
    logic [NL-1:0] exp_blink;

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NL; i++) fs[i] = -1;
            exp_rgb = '0; exp_any = 1'b0; exp_idx = '0; exp_blink = '0;
        end else begin
            exp_rgb = background_RGB; exp_any = 1'b0; exp_idx = '0;
            for (int i = 0; i < NL; i++) begin
                if (!exp_any && layer_DR[i] && layer_RGB[i*W +: W] != 8'hFF
                    && !(fs[i] >= 0 && (fs[i] % 2) == 1)) begin
                    exp_any = 1'b1;
                    exp_idx = 3'(i);
                    exp_rgb = layer_RGB[i*W +: W];
                end
            end
            for (int i = 0; i < NL; i++) begin
                if (blink_req[i]) fs[i] = 0;
                else if (fs[i] >= 0 && startOfFrame) begin
                    fs[i] = fs[i] + 1;
                    if (fs[i] == BF) fs[i] = -1;
                end
                exp_blink[i] = (fs[i] >= 0);
            end
        end
    end

    // Scoreboard compare on every cycle.
    always @(posedge clk) begin
        #1;
        chk("cyc_rgb", 32'(RGBOut), 32'(exp_rgb));
        chk("cyc_any", 32'(any_DR), 32'(exp_any));
        chk("cyc_idx", 32'(winner_idx), 32'(exp_idx));
        chk("cyc_blink", 32'(blinking), 32'(exp_blink));
    end

    // Driver tasks.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_layer(input int i, input logic [W-1:0] c);
        layer_RGB[i*W +: W] = c;
    endtask

    task automatic sof_pulse();
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        step();
    endtask

    task automatic blink_pulse(input int i);
        blink_req[i] = 1'b1;
        step();
        blink_req[i] = 1'b0;
        step();
    endtask

    task automatic chk_pix(input string name, input logic [W-1:0] rgb,
                           input logic any, input logic [2:0] idx);
        chk({name, "_rgb"}, 32'(RGBOut), 32'(rgb));
        chk({name, "_any"}, 32'(any_DR), 32'(any));
        chk({name, "_idx"}, 32'(winner_idx), 32'(idx));
    endtask

    initial begin
        resetN = 1'b0; startOfFrame = 1'b0; layer_DR = '0; layer_RGB = '0;
        blink_req = '0; background_RGB = 8'h49;
        #3;
        chk_pix("reset", 8'h00, 1'b0, 3'd0);
        chk("reset_blink", 32'(blinking), 32'h0);

        // Outputs hold reset values until the first edge after release.
        layer_DR = 8'b0000_0001; set_layer(0, 8'h1C);
        repeat (2) @(posedge clk);
        #3 resetN = 1'b1;
        #1 chk_pix("hold", 8'h00, 1'b0, 3'd0);
        step();
        chk_pix("first", 8'h1C, 1'b1, 3'd0);

        // Plain priority.
        layer_DR = 8'b0000_0110; set_layer(1, 8'h1C); set_layer(2, 8'hE0);
        step();
        chk_pix("prio", 8'h1C, 1'b1, 3'd1);

        // A transparent layer falls through, and no draw selects the background.
        layer_DR = 8'b0000_0011; set_layer(0, 8'hFF); set_layer(1, 8'h03);
        step();
        chk_pix("transp", 8'h03, 1'b1, 3'd1);
        layer_DR = 8'b0000_0000;
        step();
        chk_pix("bg", 8'h49, 1'b0, 3'd0);
        layer_DR = 8'b1000_0000; set_layer(7, 8'h5A);
        step();
        chk_pix("top", 8'h5A, 1'b1, 3'd7);

        // Full blink on layer 0 over layer 1.
        layer_DR = 8'b0000_0011; set_layer(0, 8'h1C); set_layer(1, 8'h03);
        blink_pulse(0);
        chk_pix("blk_start", 8'h1C, 1'b1, 3'd0);
        chk("blk_start_b", 32'(blinking[0]), 32'h1);
        for (int k = 1; k <= BF; k++) begin
            sof_pulse();
            chk("blk_rgb", 32'(RGBOut), (k % 2 == 1 && k < BF) ? 32'h03 : 32'h1C);
            chk("blk_b", 32'(blinking[0]), (k < BF) ? 32'h1 : 32'h0);
        end
        repeat (3) sof_pulse();
        chk_pix("blk_steady", 8'h1C, 1'b1, 3'd0);

        // Restart with a coincident frame start while counter = 3 and phase = 1.
        blink_pulse(0);
        repeat (13) sof_pulse();
        chk("rst_hidden", 32'(RGBOut), 32'h03);
        blink_req[0] = 1'b1; startOfFrame = 1'b1;
        step();
        blink_req[0] = 1'b0; startOfFrame = 1'b0;
        step();
        chk_pix("restart_vis", 8'h1C, 1'b1, 3'd0);
        for (int k = 1; k <= BF; k++) begin
            sof_pulse();
            chk("restart_b", 32'(blinking[0]), (k < BF) ? 32'h1 : 32'h0);
        end

        // Two independent blinks on layers 0 and 3.
        layer_DR = 8'b0000_1001; set_layer(3, 8'hE0);
        blink_pulse(0);
        repeat (5) sof_pulse();
        blink_pulse(3);
        chk("two_b", 32'(blinking), 32'h09);
        repeat (10) sof_pulse();
        chk("two_b15", 32'(blinking), 32'h09);
        sof_pulse();
        chk("two_b16", 32'(blinking), 32'h08);
        repeat (4) sof_pulse();
        chk("two_b20", 32'(blinking), 32'h08);
        sof_pulse();
        chk("two_b21", 32'(blinking), 32'h00);

        // An asynchronous reset in the middle of a blink.
        layer_DR = 8'b0000_0011;
        blink_pulse(0);
        repeat (3) sof_pulse();
        chk("ar_hidden", 32'(RGBOut), 32'h03);
        #3 resetN = 1'b0;
        #1 chk_pix("ar_now", 8'h00, 1'b0, 3'd0);
        chk("ar_blink", 32'(blinking), 32'h0);
        step();
        #2 resetN = 1'b1;
        step();
        chk_pix("ar_after", 8'h1C, 1'b1, 3'd0);
        repeat (2) sof_pulse();
        chk_pix("ar_vis", 8'h1C, 1'b1, 3'd0);

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
